// File: rtl/lal_pkg.sv
// Shared widths, FSM state encoding and score/position record for the
// local-alignment datapath (max_of_n, global_max_tracker).
package lal_pkg;

  localparam int unsigned SCORE_BITS_WIDTH = 8;
  localparam int unsigned ROW_BITS_WIDTH   = 5;
  localparam int unsigned COL_BITS_WIDTH   = 5;
  localparam int unsigned BEAT_BITS_WIDTH  = 10;

  typedef enum logic [1:0] {
    GMT_IDLE  = 2'd0,
    GMT_TRACK = 2'd1,
    GMT_DONE  = 2'd2
  } gmt_state_e;

  typedef struct packed {
    logic [SCORE_BITS_WIDTH-1:0] score;
    logic [ROW_BITS_WIDTH-1:0]   row;
    logic [COL_BITS_WIDTH-1:0]   col;
  } score_pos_t;

endpackage

// File: rtl/score_pos_cmp.sv
// Load-enable for a running maximum: the first candidate always wins, later
// candidates only on a strictly greater unsigned score (ties keep the earlier).
module score_pos_cmp #(
  parameter int unsigned SCORE_BITS_WIDTH = lal_pkg::SCORE_BITS_WIDTH
) (
  input  logic                        i_seen,
  input  logic [SCORE_BITS_WIDTH-1:0] i_cur_score,
  input  logic [SCORE_BITS_WIDTH-1:0] i_cand_score,
  output logic                        o_load
);

  always_comb begin
    o_load = !i_seen || (i_cand_score > i_cur_score);
  end

endmodule

// File: rtl/global_max_tracker.sv
// Running global maximum (score, row, col) over all anti-diagonal beats of one
// alignment. Optional beat counter under `GLOBAL_MAX_TRACKER_BEAT_COUNT_EN.
module global_max_tracker #(
  parameter int unsigned SCORE_BITS_WIDTH = lal_pkg::SCORE_BITS_WIDTH,
  parameter int unsigned ROW_BITS_WIDTH   = lal_pkg::ROW_BITS_WIDTH,
  parameter int unsigned COL_BITS_WIDTH   = lal_pkg::COL_BITS_WIDTH,
  parameter int unsigned BEAT_BITS_WIDTH  = lal_pkg::BEAT_BITS_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [SCORE_BITS_WIDTH-1:0] in_score,
  input  logic [ROW_BITS_WIDTH-1:0]   in_row,
  input  logic [COL_BITS_WIDTH-1:0]   in_col,
  output logic                        in_ready,
  output logic                        busy,
  output logic                        done,
  output logic [SCORE_BITS_WIDTH-1:0] max_score,
  output logic [ROW_BITS_WIDTH-1:0]   max_row,
  output logic [COL_BITS_WIDTH-1:0]   max_col
`ifdef GLOBAL_MAX_TRACKER_BEAT_COUNT_EN
  ,
  output logic [BEAT_BITS_WIDTH-1:0]  beat_cnt,
  output logic                        beat_ovf
`endif
);

  import lal_pkg::*;

  gmt_state_e                  r_state;
  logic                        r_seen;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_in_ready;
  logic [SCORE_BITS_WIDTH-1:0] r_max_score;
  logic [ROW_BITS_WIDTH-1:0]   r_max_row;
  logic [COL_BITS_WIDTH-1:0]   r_max_col;
  logic                        w_load;
  logic                        w_accept;

`ifdef GLOBAL_MAX_TRACKER_BEAT_COUNT_EN
  logic [BEAT_BITS_WIDTH-1:0]  r_beat_cnt;
  logic                        r_beat_ovf;
`endif

  score_pos_cmp #(
    .SCORE_BITS_WIDTH (SCORE_BITS_WIDTH)
  ) u_cmp (
    .i_seen       (r_seen),
    .i_cur_score  (r_max_score),
    .i_cand_score (in_score),
    .o_load       (w_load)
  );

  always_comb begin
    w_accept = (r_state == GMT_TRACK) && in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= GMT_IDLE;
      r_seen      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_max_score <= '0;
      r_max_row   <= '0;
      r_max_col   <= '0;
`ifdef GLOBAL_MAX_TRACKER_BEAT_COUNT_EN
      r_beat_cnt  <= '0;
      r_beat_ovf  <= 1'b0;
`endif
    end else if (start) begin
      // start outranks any beat presented in the same cycle
      r_state     <= GMT_TRACK;
      r_seen      <= 1'b0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_max_score <= '0;
      r_max_row   <= '0;
      r_max_col   <= '0;
`ifdef GLOBAL_MAX_TRACKER_BEAT_COUNT_EN
      r_beat_cnt  <= '0;
      r_beat_ovf  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_seen <= 1'b1;
      if (w_load) begin
        r_max_score <= in_score;
        r_max_row   <= in_row;
        r_max_col   <= in_col;
      end
`ifdef GLOBAL_MAX_TRACKER_BEAT_COUNT_EN
      if (r_beat_cnt == '1) begin
        r_beat_ovf <= 1'b1;
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
`endif
      if (in_last) begin
        r_state    <= GMT_DONE;
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
        r_in_ready <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign max_score = r_max_score;
  assign max_row   = r_max_row;
  assign max_col   = r_max_col;

`ifdef GLOBAL_MAX_TRACKER_BEAT_COUNT_EN
  assign beat_cnt  = r_beat_cnt;
  assign beat_ovf  = r_beat_ovf;
`endif

endmodule

// File: tb/tb_global_max_tracker.sv
// Self-checking bench for global_max_tracker: directed cases plus random
// traffic against a per-alignment beat-list reference model.
module tb_global_max_tracker;

  import lal_pkg::*;

  localparam int unsigned SW = 8;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 5;
`ifdef GLOBAL_MAX_TRACKER_BEAT_COUNT_EN
  localparam int unsigned BW = 2;
`else
  localparam int unsigned BW = 10;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [SW-1:0] in_score = '0;
  logic [RW-1:0] in_row = '0;
  logic [CW-1:0] in_col = '0;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic [SW-1:0] max_score;
  logic [RW-1:0] max_row;
  logic [CW-1:0] max_col;
`ifdef GLOBAL_MAX_TRACKER_BEAT_COUNT_EN
  logic [BW-1:0] beat_cnt;
  logic          beat_ovf;
`endif

  global_max_tracker #(
    .SCORE_BITS_WIDTH (SW),
    .ROW_BITS_WIDTH   (RW),
    .COL_BITS_WIDTH   (CW),
    .BEAT_BITS_WIDTH  (BW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_score  (in_score),
    .in_row    (in_row),
    .in_col    (in_col),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .max_score (max_score),
    .max_row   (max_row),
    .max_col   (max_col)
`ifdef GLOBAL_MAX_TRACKER_BEAT_COUNT_EN
    ,
    .beat_cnt  (beat_cnt),
    .beat_ovf  (beat_ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model: 0 idle, 1 tracking, 2 done; q holds every accepted beat of the alignment
  int         phase = 0;
  score_pos_t q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic score_pos_t model_max();
    score_pos_t best = '0;
    foreach (q[i]) begin
      if (i == 0 || q[i].score > best.score) best = q[i];
    end
    return best;
  endfunction

  task automatic check_outputs(input string tag);
    score_pos_t exp = model_max();
    chk({tag, ".busy"},     32'(busy),      32'(phase == 1));
    chk({tag, ".in_ready"}, 32'(in_ready),  32'(phase == 1));
    chk({tag, ".done"},     32'(done),      32'(phase == 2));
    chk({tag, ".score"},    32'(max_score), 32'(exp.score));
    chk({tag, ".row"},      32'(max_row),   32'(exp.row));
    chk({tag, ".col"},      32'(max_col),   32'(exp.col));
`ifdef GLOBAL_MAX_TRACKER_BEAT_COUNT_EN
    begin
      int sat = (1 << BW) - 1;
      int n   = q.size();
      chk({tag, ".beat_cnt"}, 32'(beat_cnt), 32'((n > sat) ? sat : n));
      chk({tag, ".beat_ovf"}, 32'(beat_ovf), 32'(n > sat));
    end
`endif
  endtask

  task automatic step(input string tag, input logic r, input logic s, input logic v,
                      input logic l, input int sc, input int rw, input int cl);
    score_pos_t b;
    rst      = r;
    start    = s;
    in_valid = v;
    in_last  = l;
    in_score = SW'(sc);
    in_row   = RW'(rw);
    in_col   = CW'(cl);
    @(posedge clk);
    if (r) begin
      phase = 0;
      q.delete();
    end else if (s) begin
      phase = 1;
      q.delete();
    end else if (phase == 1 && v) begin
      b.score = SW'(sc);
      b.row   = RW'(rw);
      b.col   = CW'(cl);
      q.push_back(b);
      if (l) phase = 2;
    end
    #1;
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_outputs(tag);
  endtask

  task automatic beat(input string tag, input int sc, input int rw, input int cl, input logic l);
    step(tag, 1'b0, 1'b0, 1'b1, l, sc, rw, cl);
  endtask

  initial begin
    step("reset0", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    step("reset1", 1'b1, 1'b0, 1'b1, 1'b1, 77, 3, 3);
    step("idle_beat", 1'b0, 1'b0, 1'b1, 1'b0, 99, 1, 1);

    // basic: strict max across crossing scores
    step("basic_start", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    beat("basic_b0", 127, 0, 0, 1'b0);
    beat("basic_b1", 128, 0, 1, 1'b0);
    beat("basic_b2", 110, 1, 0, 1'b0);
    beat("basic_b3", 2, 1, 1, 1'b1);
    chk("basic_final_score", 32'(max_score), 32'd128);
    chk("basic_final_col",   32'(max_col),   32'd1);
    step("done_hold", 1'b0, 1'b0, 1'b1, 1'b1, 250, 7, 7);

    // ties keep the earlier position
    step("tie_start", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    beat("tie_b0", 9, 0, 2, 1'b0);
    beat("tie_b1", 18, 0, 3, 1'b0);
    beat("tie_b2", 18, 1, 2, 1'b0);
    beat("tie_b3", 0, 1, 3, 1'b1);
    chk("tie_final_row", 32'(max_row), 32'd0);

    // all-zero alignment still captures the first position
    step("zero_start", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    step("zero_lastnv", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    beat("zero_b0", 0, 3, 4, 1'b0);
    beat("zero_b1", 0, 0, 0, 1'b1);
    chk("zero_final_row", 32'(max_row), 32'd3);

    // start mid-TRACK discards the concurrent beat
    step("restart_start", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    beat("restart_b0", 40, 2, 2, 1'b0);
    step("restart_mid", 1'b0, 1'b1, 1'b1, 1'b0, 200, 6, 6);
    beat("restart_b1", 5, 1, 1, 1'b1);

    // rst mid-TRACK, later beats ignored until start
    step("rst_start", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    beat("rst_b0", 50, 2, 2, 1'b0);
    step("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    beat("rst_after", 60, 3, 3, 1'b0);
    step("rst_vs_start", 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);

    // long alignment: exercises counter saturation when enabled
    step("long_start", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 5; i++) beat("long_b", 10 + i, i, i, 1'b0);
    beat("long_last", 3, 9, 9, 1'b1);

    // empty alignment re-started: max stays zero
    step("empty_start", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    step("empty_idle", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    step("empty_start2", 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      logic r = ($urandom_range(0, 79) == 0);
      logic s = ($urandom_range(0, 14) == 0);
      logic v = ($urandom_range(0, 3) != 0);
      logic l = ($urandom_range(0, 9) == 0);
      int   sc = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) * 64 : $urandom_range(0, 255);
      step("rand", r, s, v, l, sc, $urandom_range(0, 31), $urandom_range(0, 31));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
